// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory port between icache fills and dcache fills/writebacks.
// Define MEM_PORT_ARBITER_RR_EN for round-robin tie-breaking; otherwise dcache has fixed priority.
//
// state | meaning
// IDLE  | port free, arbitrate pending requests
// BUSY  | memory transaction in flight, latency counter running
// RESP  | one-cycle ack to the granted requester
module mem_port_arbiter #(
    parameter int MEM_LATENCY = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           ic_req,
    input  logic [19:0]    ic_addr,
    output logic           ic_ack,
    output logic [127:0]   ic_line,
    input  logic           dc_req,
    input  logic           dc_we,
    input  logic [19:0]    dc_addr,
    input  logic [127:0]   dc_wdata,
    output logic           dc_ack,
    output logic [127:0]   dc_line,
    output logic           mem_req,
    output logic           mem_we,
    output logic [19:0]    mem_addr,
    output logic [127:0]   mem_wdata,
    input  logic [127:0]   mem_rdata
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [19:4]        addr_q;
    logic               we_q;
    logic [127:0]       wdata_q;
    logic [127:0]       line_q;
    logic               gnt_dc_q;
    logic               pick_dc;
    logic               start;
    logic               busy;

`ifdef MEM_PORT_ARBITER_RR_EN
    logic last_dc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_dc <= 1'b0;
        end else if (state == RESP) begin
            last_dc <= gnt_dc_q;
        end
    end

    // On a tie the requester not served last wins.
    always_comb begin
        pick_dc = dc_req && (!ic_req || !last_dc);
    end
`else
    always_comb begin
        pick_dc = dc_req;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ic_req || dc_req) state_nxt = BUSY;
            BUSY:    if (cnt == '0) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign start = (state == IDLE) && (ic_req || dc_req);
    assign busy  = (state == BUSY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            gnt_dc_q <= 1'b0;
            line_q   <= '0;
        end else begin
            if (start) begin
                gnt_dc_q <= pick_dc;
                we_q     <= pick_dc && dc_we;
                addr_q   <= pick_dc ? dc_addr[19:4] : ic_addr[19:4];
                wdata_q  <= (pick_dc && dc_we) ? dc_wdata : '0;
                cnt      <= CNT_LOAD;
            end else if (busy && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
            // Writebacks leave the shared line register untouched.
            if (busy && (cnt == '0) && !we_q) begin
                line_q <= mem_rdata;
            end
        end
    end

    assign mem_req   = busy;
    assign mem_we    = busy && we_q;
    assign mem_addr  = {addr_q, 4'b0000};
    assign mem_wdata = (busy && we_q) ? wdata_q : '0;
    assign ic_ack    = (state == RESP) && !gnt_dc_q;
    assign dc_ack    = (state == RESP) && gnt_dc_q;
    assign ic_line   = line_q;
    assign dc_line   = line_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: two instances (latency 5 and 1) checked against a
// transaction-level model of grant time, busy window, ack cycle and returned line.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   rate = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    int   run;
    logic found;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_u
        localparam int L = (g == 0) ? 5 : 1;

        logic         ic_req, dc_req, dc_we, ic_ack, dc_ack, mem_req, mem_we;
        logic [19:0]  ic_addr, dc_addr, mem_addr;
        logic [127:0] dc_wdata, ic_line, dc_line, mem_wdata, mem_rdata;

        mem_port_arbiter #(.MEM_LATENCY(L)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .ic_req    (ic_req),
            .ic_addr   (ic_addr),
            .ic_ack    (ic_ack),
            .ic_line   (ic_line),
            .dc_req    (dc_req),
            .dc_we     (dc_we),
            .dc_addr   (dc_addr),
            .dc_wdata  (dc_wdata),
            .dc_ack    (dc_ack),
            .dc_line   (dc_line),
            .mem_req   (mem_req),
            .mem_we    (mem_we),
            .mem_addr  (mem_addr),
            .mem_wdata (mem_wdata),
            .mem_rdata (mem_rdata)
        );

        // Reference model: a grant at sampling edge k occupies the port for edges k..k+L+1,
        // memory is busy after edges k..k+L-1, data sampled at edge k+L, ack after edge k+L.
        longint       cyc = 0;
        longint       k_start = 0;
        longint       free_at = 0;
        logic         act = 1'b0;
        logic         g_dc = 1'b0;
        logic         g_we = 1'b0;
        logic         last_dc = 1'b0;
        logic         pick;
        logic [19:0]  g_addr = '0;
        logic [127:0] g_wdata = '0;
        logic [127:0] exp_line = '0;

        initial begin
            forever begin
                @(posedge clk or negedge rst_n);
                if (!rst_n) begin
                    cyc = 0; act = 1'b0; free_at = 0; exp_line = '0;
                    last_dc = 1'b0; g_dc = 1'b0; g_we = 1'b0; g_addr = '0; g_wdata = '0;
                end else begin
                    cyc = cyc + 1;
                    if (act && cyc == k_start + L && !g_we) exp_line = mem_rdata;
                    if (cyc >= free_at && (ic_req || dc_req)) begin
`ifdef MEM_PORT_ARBITER_RR_EN
                        pick = dc_req && (!ic_req || !last_dc);
`else
                        pick = dc_req;
`endif
                        last_dc = pick;
                        g_dc    = pick;
                        g_we    = pick && dc_we;
                        g_addr  = pick ? dc_addr : ic_addr;
                        g_wdata = (pick && dc_we) ? dc_wdata : '0;
                        act     = 1'b1;
                        k_start = cyc;
                        free_at = cyc + L + 2;
                    end
                end
            end
        end

        wire e_busy = act && (cyc >= k_start) && (cyc < k_start + L);
        wire e_ack  = act && (cyc == k_start + L);

        always @(negedge clk) begin
            if (!rst_n) begin
                chk($sformatf("L%0d rst mem_req", L), mem_req, 1'b0);
                chk($sformatf("L%0d rst mem_we", L), mem_we, 1'b0);
                chk($sformatf("L%0d rst mem_addr", L), mem_addr, 20'h0);
                chk($sformatf("L%0d rst mem_wdata", L), mem_wdata, 128'h0);
                chk($sformatf("L%0d rst acks", L), {ic_ack, dc_ack}, 2'b00);
                chk($sformatf("L%0d rst line", L), ic_line | dc_line, 128'h0);
            end else begin
                chk($sformatf("L%0d mem_req", L), mem_req, e_busy);
                chk($sformatf("L%0d mem_we", L), mem_we, e_busy && g_we);
                chk($sformatf("L%0d mem_wdata", L), mem_wdata, (e_busy && g_we) ? g_wdata : 128'h0);
                if (e_busy) chk($sformatf("L%0d mem_addr", L), mem_addr, {g_addr[19:4], 4'h0});
                chk($sformatf("L%0d ic_ack", L), ic_ack, e_ack && !g_dc);
                chk($sformatf("L%0d dc_ack", L), dc_ack, e_ack && g_dc);
                chk($sformatf("L%0d ic_line", L), ic_line, exp_line);
                chk($sformatf("L%0d dc_line", L), dc_line, exp_line);
            end
        end

        // Requester agents: hold until ack, drop the cycle after, may re-raise the cycle after that.
        initial begin
            logic ic_done, dc_done;
            ic_req = 1'b0; dc_req = 1'b0; dc_we = 1'b0;
            ic_addr = '0; dc_addr = '0; dc_wdata = '0; mem_rdata = '0;
            forever begin
                @(negedge clk);
                ic_done = ic_ack;
                dc_done = dc_ack;
                @(posedge clk);
                #1;
                mem_rdata = {$urandom, $urandom, $urandom, $urandom};
                if (!rst_n) begin
                    ic_req = 1'b0;
                    dc_req = 1'b0;
                end else begin
                    if (ic_done) begin
                        ic_req = 1'b0;
                    end else if (!ic_req && ($urandom_range(99) < rate)) begin
                        ic_req  = 1'b1;
                        ic_addr = 20'($urandom);
                    end
                    if (dc_done) begin
                        dc_req = 1'b0;
                    end else if (!dc_req && ($urandom_range(99) < rate)) begin
                        dc_req   = 1'b1;
                        dc_we    = 1'($urandom_range(1));
                        dc_addr  = 20'($urandom);
                        dc_wdata = {$urandom, $urandom, $urandom, $urandom};
                    end
                end
            end
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        rate = 100;
        repeat (300) @(posedge clk);
        rate = 40;
        repeat (1200) @(posedge clk);
        rate = 8;
        repeat (400) @(posedge clk);

        // Async reset in the third busy cycle of the latency-5 instance.
        rate  = 60;
        run   = 0;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (gen_u[0].mem_req) run++;
            else run = 0;
            if (run == 3) found = 1'b1;
        end
        chk("rst_window_found", found, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async mem_req L5", gen_u[0].mem_req, 1'b0);
        chk("async mem_req L1", gen_u[1].mem_req, 1'b0);
        chk("async acks L5", {gen_u[0].ic_ack, gen_u[0].dc_ack}, 2'b00);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        rate = 30;
        repeat (600) @(posedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequences and shares the single main-memory port between the instruction-cache fill path and the data-cache fill/writeback path. Each transaction moves one 128-bit cacheline addressed by a 20-bit physical pointer. The block sits between the two cache controllers and the memory model. It serialises their misses through a fixed-latency bus protocol and returns exactly one acknowledge per granted request.

## Interface
- MEM_LATENCY, 5, memory access cycles per transaction (≥1)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ic_req  in  1  icache line-fill request; held until ic_ack
- ic_addr  in  20  icache physical address (pptr_t)
- ic_ack  out  1  one-cycle pulse, fill complete, ic_line valid
- ic_line  out  128  fill data (cacheline_t)
- dc_req  in  1  dcache request; held until dc_ack
- dc_we  in  1  1 = writeback of dc_wdata, 0 = line fill
- dc_addr  in  20  dcache physical address
- dc_wdata  in  128  writeback data
- dc_ack  out  1  one-cycle pulse, transaction complete
- dc_line  out  128  fill data, valid with dc_ack when dc_we=0
- mem_req  out  1  memory transaction in progress
- mem_we  out  1  write transaction
- mem_addr  out  20  line-aligned address
- mem_wdata  out  128  write data
- mem_rdata  in  128  read data, sampled on final BUSY cycle

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - No request: stay in IDLE.
  - Any request: latch the winner's addr/we/wdata and the grant id, load the counter with MEM_LATENCY-1, go to BUSY.
- BUSY:
  - mem_req=1; mem_we/mem_addr/mem_wdata driven from the latched values.
  - Counter decrements each cycle.
  - When the counter is 0 and the transaction is a read, capture mem_rdata into the line register; go to RESP.
- RESP: assert the granted ack for one cycle, update the last-grant bit, go to IDLE.
- mem_addr = {latched_addr[19:4], 4'b0000}. Byte offset bits are always cleared.
- ic_line and dc_line both drive the shared line register. A write transaction does not change the line register.
- mem_wdata is 0 for reads; mem_we is 0 outside BUSY.
- Counter width is $clog2(MEM_LATENCY) bits, minimum 1.
- Requester rule: req and its inputs stay stable until ack. req is low in the cycle after ack. A new request may be raised in the second cycle after ack.
- Arbitration applies only in IDLE. Requests arriving during BUSY or RESP wait.
- Reset, async at any time including mid-BUSY: state=IDLE, counter=0, line register=0, last-grant=icache, latched fields=0. The transaction is aborted with no ack. mem_req falls without waiting for a clock.
- Reset values of all outputs: 0.

## Timing
- Request sampled high in IDLE at edge t: BUSY for cycles t+1 … t+MEM_LATENCY.
- mem_rdata is sampled at edge t+MEM_LATENCY. RESP, with ack high, occupies cycle t+MEM_LATENCY+1.
- Request-to-ack latency is MEM_LATENCY+1 cycles. Back-to-back period is MEM_LATENCY+2 cycles.
- A waiting second requester is granted in the IDLE cycle directly after RESP.
- No combinational path from req inputs to any output.

## Configuration
- MEM_PORT_ARBITER_RR_EN defined: round-robin on simultaneous requests in IDLE.
  - The requester not granted last wins.
  - After reset, last-grant=icache, so dcache wins the first tie.
- Undefined: fixed priority, dcache always wins ties. The last-grant register is not built.
- Single-requester behaviour is identical in both builds.

## Test plan
- Lone icache fill, ic_addr=0x1234F, MEM_LATENCY=5, mem_rdata=0xA5…A5 → mem_addr=0x12340, mem_we=0, ic_ack 6 cycles after req, ic_line=0xA5…A5, dc_ack stays 0.
- dcache writeback, dc_addr=0x00010, dc_wdata=0xDEADBEEF… → mem_we=1, mem_wdata matches during all 5 BUSY cycles, dc_ack at +6, line register unchanged.
- Simultaneous ic_req and dc_req held for two rounds:
  - RR build: dc granted first, ic second, alternating thereafter.
  - Fixed build: dc granted every tie.
  - Each loser is acked 7 cycles after the winner's ack.
- dc_req raised during an icache BUSY → dc granted in the IDLE cycle after ic_ack; no request lost or duplicated.
- rst_n dropped in the 3rd BUSY cycle → mem_req=0 immediately; no ack; after release, a new ic_req completes in 6 cycles.
- MEM_LATENCY=1 → ack 2 cycles after req; back-to-back requests every 3 cycles.
